latch_write_arbiter: RTL and testbench
======================================

# latch_write_arbiter

Sequencer and two-way arbiter for a bank of gated D latches (the lab gate-level D latch, replicated W bits × N_LATCH words). It accepts write requests from two synchronous requesters, chooses one per transaction by round-robin, and drives the shared latch data bus and per-word enables. Each write runs a fixed setup → enable pulse → hold sequence, so D is never changing while E is high. It sits between the clocked requesters and the level-sensitive latch bank.

## Interface
- W, 8, latch word width
- N_LATCH, 4, number of latch words; address width AW = $clog2(N_LATCH)
- T_SETUP, 2, cycles D is stable before E rises (≥1)
- T_PULSE, 2, cycles E is held high (≥1)
- T_HOLD, 1, cycles D stays stable after E falls (≥1)

- clk  in  1  rising-edge clock; one clock domain only
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  write request from requester 0 / 1
- addr0 / addr1  in  AW  target word; stable while req high
- data0 / data1  in  W  write data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1
- lat_d  out  W  shared D bus to all latch words
- lat_en  out  N_LATCH  one-hot E per latch word
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE.
- IDLE: if any req is high, grant one (both high → requester named by priority pointer; pointer resets to 0). Capture granted addr/data into internal registers, load phase counter, go to SETUP.
- SETUP: lat_d = captured data, lat_en = 0, for T_SETUP cycles, then PULSE.
- PULSE: lat_en[addr] = 1, all other bits 0, for T_PULSE cycles, then HOLD.
- HOLD: lat_en = 0, lat_d unchanged, for T_HOLD cycles, then DONE.
- DONE: ack of granted requester = 1 for exactly this cycle; priority pointer set to the non-granted requester; next state IDLE. No request is sampled in DONE.
- Requester contract: drop req on the clock edge where ack is seen high (req <= req & ~ack). A req still high in IDLE is a new request.
- Req dropped mid-transaction: transaction completes; ack still issued.
- addr ≥ N_LATCH: full sequence and ack run; no lat_en bit asserts.
- lat_d keeps the last written value in IDLE; never changes outside IDLE→SETUP transition.
- All outputs registered; lat_en glitch-free.

## Timing
- Reset (asynchronous, immediate): state IDLE, lat_en = 0, lat_d = 0, ack0 = ack1 = 0, busy = 0, pointer = 0. Reset during PULSE drops lat_en at once; no ack is produced for the aborted write.
- Latency, req sampled high in IDLE at cycle 0: SETUP cycles 1..T_SETUP, PULSE next T_PULSE cycles, HOLD next T_HOLD, ack in cycle 1+T_SETUP+T_PULSE+T_HOLD. Defaults: lat_d valid cycle 1, lat_en high cycles 3–4, ack cycle 6.
- Back-to-back: second request sampled in the IDLE cycle after DONE; throughput one write per T_SETUP+T_PULSE+T_HOLD+2 cycles (7 default).
- Phase counter width $clog2(max(T_SETUP,T_PULSE,T_HOLD)+1); counts down, leaves phase at 1.

## Structure
- Package latch_ctrl_pkg: FSM state enum, default timing constants, and a helper function for the phase counter width.
- Sub-module rr_arb2: 2-input round-robin arbiter (req0, req1, pointer → grant one-hot); the pointer update stays in the top FSM.
- Top module: FSM, phase counter, capture registers, output registers.

## Test plan
- Reset values: hold rst_n low → all outputs 0; assert rst_n low during PULSE of a write → lat_en = 0 same time step, no ack.
- Single write: req0, addr0 = 2, data0 = 8'hA5 at cycle 0 → lat_d = A5 from cycle 1, lat_en = 4'b0100 cycles 3–4 only, ack0 cycle 6, latch word 2 holds A5.
- Simultaneous requests: req0 and req1 high together from reset → requester 0 served first (ack0 cycle 6), requester 1 next (ack1 cycle 13); repeat with both high again → requester 0 wins again after 1 was last served.
- Stability check: across all writes, lat_d never changes while any lat_en bit is high and for T_HOLD cycles after it falls.
- Out-of-range/dropped: N_LATCH = 3, addr = 3 → no lat_en, ack issued; req1 dropped during SETUP → ack1 still pulses once.
- Parameter sweep: T_SETUP = T_PULSE = T_HOLD = 1 → ack at cycle 4, lat_en high exactly cycle 2.

Source files
------------

// File: rtl/latch_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : latch_ctrl_pkg
//  Description : Shared state encodings, default timing constants and width
//                helpers for the gated-latch write sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package latch_ctrl_pkg;

   // Default geometry and write timing
   localparam int unsigned DEF_W       = 8;
   localparam int unsigned DEF_N_LATCH = 4;
   localparam int unsigned DEF_T_SETUP = 2;
   localparam int unsigned DEF_T_PULSE = 2;
   localparam int unsigned DEF_T_HOLD  = 1;

   // Write sequencer state encoding
   typedef logic [2:0] state_t;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_PULSE = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Phase counter must hold the longest of the three phase lengths
   function automatic int unsigned phase_cnt_width(input int unsigned t_setup,
                                                   input int unsigned t_pulse,
                                                   input int unsigned t_hold);
      int unsigned m;
      m = t_setup;
      if (t_pulse > m) m = t_pulse;
      if (t_hold  > m) m = t_hold;
      return $clog2(m + 1);
   endfunction

   // Word address width; never below one bit so a single-word bank still has a port
   function automatic int unsigned addr_width(input int unsigned n_latch);
      return (n_latch > 1) ? $clog2(n_latch) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/latch_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : latch_write_arbiter_if
//  Description : Requester handshake and latch-bank bus of the write arbiter.
//                master = requester/bank side, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface latch_write_arbiter_if #(
   parameter int unsigned W       = 8,
   parameter int unsigned N_LATCH = 4
);
   import latch_ctrl_pkg::*;

   localparam int unsigned AW = addr_width(N_LATCH);

   logic          req0;
   logic          req1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [W-1:0]  data0;
   logic [W-1:0]  data1;
   logic          ack0;
   logic          ack1;
   logic [W-1:0]  lat_d;
   logic [N_LATCH-1:0] lat_en;
   logic          busy;

   modport master (
      output req0, req1, addr0, addr1, data0, data1,
      input  ack0, ack1, lat_d, lat_en, busy
   );

   modport slave (
      input  req0, req1, addr0, addr1, data0, data1,
      output ack0, ack1, lat_d, lat_en, busy
   );

endinterface
`default_nettype wire

// File: rtl/latch_write_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin grant. When both request, ptr names the
//                winner; a lone request always wins. Pointer state lives in the
//                caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       ptr,
   output logic [1:0] gnt
);

   // One-hot grant, ties broken by the pointer
   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req0 & (~req1 | ~ptr);
      gnt[1] = req1 & (~req0 |  ptr);
   end

endmodule
`default_nettype wire

// File: rtl/latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : latch_write_arbiter
//  Description : Arbitrates two write requesters onto a bank of gated D latches
//                and sequences each write as setup -> enable pulse -> hold so D
//                never moves while any E is high. All bank outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module latch_write_arbiter
   import latch_ctrl_pkg::*;
#(
   parameter int unsigned W       = DEF_W,
   parameter int unsigned N_LATCH = DEF_N_LATCH,
   parameter int unsigned T_SETUP = DEF_T_SETUP,
   parameter int unsigned T_PULSE = DEF_T_PULSE,
   parameter int unsigned T_HOLD  = DEF_T_HOLD
) (
   input  logic clk,
   input  logic rst_n,
   latch_write_arbiter_if.slave bus
);

   localparam int unsigned AW = addr_width(N_LATCH);
   localparam int unsigned CW = phase_cnt_width(T_SETUP, T_PULSE, T_HOLD);

   localparam logic [CW-1:0] c_setup_cnt = CW'(T_SETUP);
   localparam logic [CW-1:0] c_pulse_cnt = CW'(T_PULSE);
   localparam logic [CW-1:0] c_hold_cnt  = CW'(T_HOLD);
   localparam logic [CW-1:0] c_cnt_last  = CW'(1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;
   logic               r_ptr;
   logic [1:0]         w_gnt;
   logic [1:0]         r_gnt;
   logic [AW-1:0]      r_addr;
   logic [N_LATCH-1:0] w_en_onehot;
   logic [W-1:0]       r_lat_d;
   logic [N_LATCH-1:0] r_lat_en;
   logic [1:0]         r_ack;
   logic               r_busy;
   logic               w_start;

   rr_arb2 u_arb (
      .req0 (bus.req0),
      .req1 (bus.req1),
      .ptr  (r_ptr),
      .gnt  (w_gnt)
   );

   // A new write is accepted only from IDLE; DONE never samples requests
   assign w_start = (r_state == ST_IDLE) && (|w_gnt);

   // Next state and phase counter; each phase ends when the count reaches 1
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_SETUP;
               w_cnt_nxt   = c_setup_cnt;
            end
         end
         ST_SETUP: begin
            if (r_cnt == c_cnt_last) begin
               w_state_nxt = ST_PULSE;
               w_cnt_nxt   = c_pulse_cnt;
            end else begin
               w_cnt_nxt   = r_cnt - c_cnt_last;
            end
         end
         ST_PULSE: begin
            if (r_cnt == c_cnt_last) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = c_hold_cnt;
            end else begin
               w_cnt_nxt   = r_cnt - c_cnt_last;
            end
         end
         ST_HOLD: begin
            if (r_cnt == c_cnt_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt   = r_cnt - c_cnt_last;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Decode captured address to a word enable; out-of-range addresses select nothing
   always_comb begin
      w_en_onehot = '0;
      for (int i = 0; i < int'(N_LATCH); i++) begin
         if (r_addr == AW'(i)) w_en_onehot[i] = 1'b1;
      end
   end

   // State and phase counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Capture the winner's address and data; lat_d only moves on IDLE->SETUP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt   <= 2'b00;
         r_addr  <= '0;
         r_lat_d <= '0;
      end else if (w_start) begin
         r_gnt   <= w_gnt;
         r_addr  <= w_gnt[1] ? bus.addr1 : bus.addr0;
         r_lat_d <= w_gnt[1] ? bus.data1 : bus.data0;
      end
   end

   // Registered enable, ack and busy derived from the upcoming state (glitch-free)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lat_en <= '0;
         r_ack    <= 2'b00;
         r_busy   <= 1'b0;
      end else begin
         r_lat_en <= (w_state_nxt == ST_PULSE) ? w_en_onehot : '0;
         r_ack    <= (w_state_nxt == ST_DONE)  ? r_gnt       : 2'b00;
         r_busy   <= (w_state_nxt != ST_IDLE);
      end
   end

   // Round-robin pointer hands priority to the requester not just served
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (r_state == ST_DONE) begin
         r_ptr <= r_gnt[0];
      end
   end

   assign bus.lat_d  = r_lat_d;
   assign bus.lat_en = r_lat_en;
   assign bus.ack0   = r_ack[0];
   assign bus.ack1   = r_ack[1];
   assign bus.busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_latch_write_arbiter
//  Description : Directed bench for latch_write_arbiter: default-timing
//                instance with ack scoreboard, latch-bank model and D-stability
//                monitor, plus a 3-word, single-cycle-phase instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_write_arbiter;
   import latch_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   c0;

   always #5 clk = ~clk;

   // Free-running cycle index; cycle k is the period after the k-th edge
   always @(posedge clk) cyc <= cyc + 1;

   latch_write_arbiter_if #(.W(8), .N_LATCH(4)) a_if ();
   latch_write_arbiter_if #(.W(8), .N_LATCH(3)) b_if ();

   latch_write_arbiter #(.W(8), .N_LATCH(4), .T_SETUP(2), .T_PULSE(2), .T_HOLD(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if.slave)
   );

   latch_write_arbiter #(.W(8), .N_LATCH(3), .T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected acks for instance A: who, cycle and the data on the bus
   typedef struct {
      logic [1:0] who;
      int         cyc;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      if (rst_n && (a_if.ack0 || a_if.ack1)) begin
         if (sb.size() == 0) begin
            chk("a_unexpected_ack", {30'd0, a_if.ack1, a_if.ack0}, 32'd0);
         end else begin : pop_blk
            exp_t e;
            e = sb.pop_front();
            chk("a_ack_who",  {30'd0, a_if.ack1, a_if.ack0}, {30'd0, e.who});
            chk("a_ack_cyc",  cyc, e.cyc);
            chk("a_ack_data", {24'd0, a_if.lat_d}, {24'd0, e.data});
         end
      end
   end

   // Behavioural gated-latch bank driven by instance A
   logic [7:0] mem_a [4];
   always_latch begin
      for (int i = 0; i < 4; i++) begin
         if (a_if.lat_en[i]) mem_a[i] <= a_if.lat_d;
      end
   end

   // D must hold while any E is high and for one hold cycle after it falls
   logic [7:0] prev_d;
   int         hold_left = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_left <= 0;
      end else begin
         if ((|a_if.lat_en) || hold_left > 0)
            chk("a_lat_d_stable", {24'd0, a_if.lat_d}, {24'd0, prev_d});
         hold_left <= (|a_if.lat_en) ? 1 : ((hold_left > 0) ? hold_left - 1 : 0);
      end
      prev_d <= a_if.lat_d;
   end

   initial begin
      rst_n = 1'b0;
      a_if.req0 = 0; a_if.req1 = 0; a_if.addr0 = 0; a_if.addr1 = 0; a_if.data0 = 0; a_if.data1 = 0;
      b_if.req0 = 0; b_if.req1 = 0; b_if.addr0 = 0; b_if.addr1 = 0; b_if.data0 = 0; b_if.data1 = 0;
      tick(2);

      // Reset values
      chk("rst_a_lat_en", {28'd0, a_if.lat_en}, 32'd0);
      chk("rst_a_lat_d",  {24'd0, a_if.lat_d},  32'd0);
      chk("rst_a_ack",    {30'd0, a_if.ack1, a_if.ack0}, 32'd0);
      chk("rst_a_busy",   {31'd0, a_if.busy}, 32'd0);
      chk("rst_b_lat_en", {29'd0, b_if.lat_en}, 32'd0);
      chk("rst_b_busy",   {31'd0, b_if.busy}, 32'd0);
      rst_n = 1'b1;
      tick(1);

      // Single write: word 2 <= A5
      a_if.req0 = 1; a_if.addr0 = 2; a_if.data0 = 8'hA5;
      c0 = cyc;
      sb.push_back('{2'b01, c0 + 6, 8'hA5});
      tick(1);
      chk("single_c1_d",    {24'd0, a_if.lat_d}, 32'hA5);
      chk("single_c1_en",   {28'd0, a_if.lat_en}, 32'd0);
      chk("single_c1_busy", {31'd0, a_if.busy}, 32'd1);
      tick(1);
      chk("single_c2_en", {28'd0, a_if.lat_en}, 32'd0);
      tick(1);
      chk("single_c3_en", {28'd0, a_if.lat_en}, 32'h4);
      tick(1);
      chk("single_c4_en", {28'd0, a_if.lat_en}, 32'h4);
      tick(1);
      chk("single_c5_en", {28'd0, a_if.lat_en}, 32'd0);
      tick(1);
      chk("single_c6_ack0", {31'd0, a_if.ack0}, 32'd1);
      a_if.req0 = 0;
      tick(1);
      chk("single_c7_ack0", {31'd0, a_if.ack0}, 32'd0);
      chk("single_c7_busy", {31'd0, a_if.busy}, 32'd0);
      chk("single_word2",   {24'd0, mem_a[2]}, 32'hA5);

      // Simultaneous requests straight from reset: 0 first, then 1
      rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
      a_if.req0 = 1; a_if.addr0 = 0; a_if.data0 = 8'h11;
      a_if.req1 = 1; a_if.addr1 = 1; a_if.data1 = 8'h22;
      c0 = cyc;
      sb.push_back('{2'b01, c0 + 6,  8'h11});
      sb.push_back('{2'b10, c0 + 13, 8'h22});
      tick(6);
      chk("sim1_c6_ack0", {31'd0, a_if.ack0}, 32'd1);
      a_if.req0 = 0;
      tick(7);
      chk("sim1_c13_ack1", {31'd0, a_if.ack1}, 32'd1);
      a_if.req1 = 0;
      tick(1);
      chk("sim1_idle_busy", {31'd0, a_if.busy}, 32'd0);

      // Both again after 1 was last served: 0 wins again
      a_if.req0 = 1; a_if.addr0 = 3; a_if.data0 = 8'h33;
      a_if.req1 = 1; a_if.addr1 = 0; a_if.data1 = 8'h44;
      c0 = cyc;
      sb.push_back('{2'b01, c0 + 6,  8'h33});
      sb.push_back('{2'b10, c0 + 13, 8'h44});
      tick(6);
      a_if.req0 = 0;
      tick(7);
      a_if.req1 = 0;
      tick(1);
      chk("bank_word0", {24'd0, mem_a[0]}, 32'h44);
      chk("bank_word1", {24'd0, mem_a[1]}, 32'h22);
      chk("bank_word3", {24'd0, mem_a[3]}, 32'h33);

      // Reset during PULSE: enable drops at once, no ack afterwards
      a_if.req1 = 1; a_if.addr1 = 1; a_if.data1 = 8'h55;
      tick(3);
      chk("abort_c3_en", {28'd0, a_if.lat_en}, 32'h2);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_en",   {28'd0, a_if.lat_en}, 32'd0);
      chk("abort_ack",  {30'd0, a_if.ack1, a_if.ack0}, 32'd0);
      chk("abort_busy", {31'd0, a_if.busy}, 32'd0);
      chk("abort_d",    {24'd0, a_if.lat_d}, 32'd0);
      a_if.req1 = 0;
      tick(1);
      rst_n = 1'b1;
      tick(10);

      // Instance B, single-cycle phases: enable exactly cycle 2, ack cycle 4
      b_if.req0 = 1; b_if.addr0 = 1; b_if.data0 = 8'hC3;
      tick(1);
      chk("sweep_c1_d",  {24'd0, b_if.lat_d}, 32'hC3);
      chk("sweep_c1_en", {29'd0, b_if.lat_en}, 32'd0);
      tick(1);
      chk("sweep_c2_en", {29'd0, b_if.lat_en}, 32'h2);
      tick(1);
      chk("sweep_c3_en",  {29'd0, b_if.lat_en}, 32'd0);
      chk("sweep_c3_ack", {30'd0, b_if.ack1, b_if.ack0}, 32'd0);
      tick(1);
      chk("sweep_c4_ack", {30'd0, b_if.ack1, b_if.ack0}, 32'h1);
      b_if.req0 = 0;
      tick(1);
      chk("sweep_c5_ack",  {30'd0, b_if.ack1, b_if.ack0}, 32'd0);
      chk("sweep_c5_busy", {31'd0, b_if.busy}, 32'd0);

      // Instance B, out-of-range address with req dropped in SETUP
      b_if.req1 = 1; b_if.addr1 = 3; b_if.data1 = 8'h7E;
      tick(1);
      chk("oor_c1_busy", {31'd0, b_if.busy}, 32'd1);
      b_if.req1 = 0;
      chk("oor_c1_en", {29'd0, b_if.lat_en}, 32'd0);
      tick(1);
      chk("oor_c2_en", {29'd0, b_if.lat_en}, 32'd0);
      chk("oor_c2_d",  {24'd0, b_if.lat_d}, 32'h7E);
      tick(1);
      chk("oor_c3_en", {29'd0, b_if.lat_en}, 32'd0);
      tick(1);
      chk("oor_c4_ack", {30'd0, b_if.ack1, b_if.ack0}, 32'h2);
      tick(1);
      chk("oor_c5_ack", {30'd0, b_if.ack1, b_if.ack0}, 32'd0);
      tick(1);
      chk("oor_c6_ack",  {30'd0, b_if.ack1, b_if.ack0}, 32'd0);
      chk("oor_c6_busy", {31'd0, b_if.busy}, 32'd0);

      chk("a_sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
